// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM/size enums, the latched EX bundle
// and small opcode-decode helpers.
package mem_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] res;
    logic [31:0] wd;
    logic [31:0] rd2;
    logic [4:0]  a3;
    logic [1:0]  new_cyc;
  } ex_bundle_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SW, OP_SB, OP_SH};
  endfunction

  function automatic size_e op_size(input logic [5:0] op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return BYTE;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return HALF;
    return WORD;
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      WORD:    return a != 2'b00;
      HALF:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables and data replication, load byte/half
// extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = ld_word_i;
    sel_byte  = ld_word_i[{addr_i, 3'b000} +: 8];
    sel_half  = addr_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (size_i)
      BYTE: begin
        be_o      = 4'b0001 << addr_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_i & sel_byte[7]}}, sel_byte};
      end
      HALF: begin
        be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sign_i & sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, runs the data-memory req/ready access with a
// MAX_WAIT timeout, and drives the registered MEM->WB bundle. Optional: MEM_ALIGN_EXC_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [31:0] EX_instr,
  input  logic [31:0] EX_MEM_RES,
  input  logic [31:0] EX_MEM_WD,
  input  logic [31:0] EX_MEM_RD2,
  input  logic [4:0]  EX_A3,
  input  logic [1:0]  EX_NEW,
  output logic        MEM_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        dm_timeout,
`ifdef MEM_ALIGN_EXC_EN
  output logic        mem_align_exc,
`endif
  output logic        MEM_valid,
  output logic [31:0] MEM_instr,
  output logic [4:0]  MEM_A3,
  output logic [31:0] MEM_WD,
  output logic [1:0]  MEM_NEW
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  ex_bundle_t      lat_q, ex_bundle;
  logic            mem_valid_q;
  logic [31:0]     mem_instr_q, mem_wd_q;
  logic [4:0]      mem_a3_q;
  logic [1:0]      mem_new_q;

  logic            valid_d;
  logic [31:0]     instr_d, wd_d;
  logic [4:0]      a3_d;
  logic [1:0]      new_d;

  logic [5:0]      ex_op, lat_op;
  logic            ex_mem, ex_misal, ex_start, lat_ld, lat_misal, timeout_now;
  logic [1:0]      lat_new_dec;
  logic [3:0]      be;
  logic [31:0]     wdata, ld_data;

  assign ex_bundle = '{EX_valid, EX_instr, EX_MEM_RES, EX_MEM_WD, EX_MEM_RD2, EX_A3, EX_NEW};
  assign ex_op     = EX_instr[31:26];
  assign lat_op    = lat_q.instr[31:26];
  assign ex_mem    = is_load(ex_op) || is_store(ex_op);
  assign lat_ld    = is_load(lat_op);

`ifdef MEM_ALIGN_EXC_EN
  assign ex_misal  = misaligned(op_size(ex_op), EX_MEM_RES[1:0]);
  assign lat_misal = (is_load(lat_op) || is_store(lat_op)) &&
                     misaligned(op_size(lat_op), lat_q.res[1:0]);
`else
  assign ex_misal  = 1'b0;
  assign lat_misal = 1'b0;
`endif

  // Misaligned ops (when trapped) never enter ACCESS; they retire from IDLE next cycle.
  assign ex_start    = EX_valid && ex_mem && !ex_misal;
  assign timeout_now = (state_q == ACCESS) && (cnt_q == CW'(MAX_WAIT));
  assign lat_new_dec = (lat_q.new_cyc == 2'd0) ? 2'd0 : lat_q.new_cyc - 2'd1;

  assign dm_req     = (state_q == ACCESS) && !timeout_now;
  assign MEM_stall  = dm_req && !dm_ready;
  assign dm_timeout = timeout_now;
  assign dm_we      = dm_req && is_store(lat_op);
  assign dm_be      = dm_req ? be : 4'b0000;
  assign dm_addr    = dm_req ? {lat_q.res[31:2], 2'b00} : 32'h0;
  assign dm_wdata   = dm_req ? wdata : 32'h0;

  mem_lane_align u_align (
    .size_i    (op_size(lat_op)),
    .sign_i    (op_signed(lat_op)),
    .addr_i    (lat_q.res[1:0]),
    .st_data_i (lat_q.rd2),
    .ld_word_i (dm_rdata),
    .be_o      (be),
    .wdata_o   (wdata),
    .ld_data_o (ld_data)
  );

  // Retirement value of whatever the latch holds this cycle; zeros mean a bubble to WB.
  always_comb begin
    valid_d = 1'b0;
    instr_d = '0;
    a3_d    = '0;
    wd_d    = '0;
    new_d   = '0;
    if (state_q == ACCESS) begin
      if (!MEM_stall) begin
        valid_d = 1'b1;
        instr_d = lat_q.instr;
        if (!timeout_now) begin
          a3_d  = lat_q.a3;
          wd_d  = lat_ld ? ld_data : lat_q.wd;
          new_d = lat_ld ? 2'd0 : lat_new_dec;
        end
      end
    end else if (lat_q.valid) begin
      valid_d = 1'b1;
      instr_d = lat_q.instr;
      if (!lat_misal) begin
        a3_d  = lat_q.a3;
        wd_d  = lat_q.wd;
        new_d = lat_new_dec;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= '0;
      mem_a3_q    <= '0;
      mem_wd_q    <= '0;
      mem_new_q   <= '0;
    end else begin
      mem_valid_q <= valid_d;
      mem_instr_q <= instr_d;
      mem_a3_q    <= a3_d;
      mem_wd_q    <= wd_d;
      mem_new_q   <= new_d;
      if (!MEM_stall) begin
        lat_q   <= ex_bundle;
        state_q <= ex_start ? ACCESS : IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  logic align_exc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) align_exc_q <= 1'b0;
    else        align_exc_q <= (state_q == IDLE) && lat_q.valid && lat_misal;
  end
  assign mem_align_exc = align_exc_q;
`endif

  assign MEM_valid = mem_valid_q;
  assign MEM_instr = mem_instr_q;
  assign MEM_A3    = mem_a3_q;
  assign MEM_WD    = mem_wd_q;
  assign MEM_NEW   = mem_new_q;

endmodule
